seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed scanner for the 8-digit, 7-segment display on the N4-DDR board. Consumes the 32-bit `seg7_data` word from the board-IO peripheral, which holds eight hex nibbles, digit 0 in bits [3:0]. Drives the shared cathode lines and per-digit anodes directly to the board pins. Latches a frame snapshot so CPU writes never tear a displayed frame, and inserts a blanking gap at each digit switch to suppress ghosting.

## Interface
- `DIV`, 50000: clka cycles per digit slot; frame = 8*DIV cycles.
- `GAP`, 500: blank cycles at the start of each slot; constraint 1 <= GAP < DIV.

- `clka` in 1: clock; reset `rst`, synchronous, active-high.
- `rst` in 1: synchronous reset, active-high.
- `seg7_data` in 32: eight hex nibbles from the board-IO peripheral.
- `dp_mask` in 8: bit i lights the decimal point of digit i.
- `blank_lz` in 1: 1 = blank leading-zero digits.
- `an` out 8: digit anodes, active-low, at most one low.
- `seg` out 8: cathodes {dp,g,f,e,d,c,b,a}, active-low.
- `frame_tick` out 1: one-cycle pulse per frame start.

## Operation
- State: `cnt` (0..DIV-1, width $clog2(DIV)), `idx` (0..7), `snap_data[31:0]`, `snap_dp[7:0]`, `snap_lz`.
- Slot counter: each cycle, `cnt++`. At `cnt==DIV-1`: `cnt<=0`, `idx<=idx+1` mod 8 (7 wraps to 0).
- Load cycle is any cycle with `cnt==0 && idx==0`, which includes the first cycle after reset. On its edge:
  - `snap_*` <= `seg7_data`, `dp_mask`, `blank_lz`.
  - `frame_tick` <= 1.
  - In all other cycles, `frame_tick` <= 0.
- Input changes outside the load cycle have no effect until the next frame.
- Digit value: `nib = snap_data[4*idx +: 4]`.
- Leading-zero blank: digit `idx` is blanked when `snap_lz==1`, `idx!=0`, and every nibble j >= idx is zero. Digit 0 is never LZ-blanked.
- Output next-state (registered):
  - If `cnt < GAP` or the digit is LZ-blanked: `an` = 8'hFF, `seg` = 8'hFF. A blanked digit also suppresses its DP.
  - Otherwise: `an` = ~(8'b1 << idx); `seg` = {~snap_dp[idx], decode(nib)[6:0]}.
- Decode values (dp off): 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.

## Timing
- Reset values: `an`=8'hFF, `seg`=8'hFF, `frame_tick`=0, `cnt`=0, `idx`=0, `snap_*`=0.
- `rst` held: outputs hold their reset values.
- First cycle after `rst` deasserts is a load cycle. `frame_tick` is high in the following cycle.
- Output latency: `an`/`seg` reflect (`cnt`,`idx`) one cycle later. Digit i is visible for DIV-GAP cycles per frame, i.e. slot cycles GAP+1..DIV of that slot counting the register delay.
- `frame_tick` period is exactly 8*DIV cycles.
- The snapshot updates during the gap (cnt=0 < GAP), so no partial frame is ever driven.
- `rst` mid-slot: the next cycle restores reset values. Scanning restarts at idx 0 with a fresh snapshot.
- No handshake. `seg7_data` is treated as a level, sampled only in load cycles.

## Structure
- Package `seg7_pkg` holds:
  - `SEG_BLANK` = 8'hFF and `AN_OFF` = 8'hFF.
  - The 16-entry hex→7-bit segment table as a constant array, with a `hex2seg` function.
- Sub-module `seg7_hex_decode` (combinational nibble→7-bit) wraps `hex2seg` and is reused by future display blocks.
- Top: counter/index logic, snapshot registers, LZ comparator (per-digit "upper nibbles zero" chain), output registers.

## Test plan
Bench parameters: DIV=8, GAP=2.
- **Reset:** hold `rst` 3 cycles → `an`=FF, `seg`=FF, `frame_tick`=0. After release, `frame_tick` is high exactly one cycle later, then every 64 cycles.
- **Scan:** `seg7_data`=32'h76543210, `blank_lz`=0, `dp_mask`=0.
  - Each slot: 2 cycles of `an`=FF, then 6 cycles of `an`=~(1<<i).
  - Digit 0 `seg`=C0, digit 1 F9, digit 7 F8.
  - Never more than one `an` bit low.
- **Tear-free:** set `seg7_data`=32'hFFFFFFFF while `idx`=3.
  - Digits 3..7 of the current frame still show 3..7.
  - Every digit of the next frame shows `seg`=8E.
- **Leading-zero blank:** `blank_lz`=1, `seg7_data`=32'h00000A00.
  - Digits 3..7: `an` stays FF for the whole slot.
  - Digit 2 shows 88; digits 1 and 0 show C0.
  - With `seg7_data`=0, only digit 0 lights, showing C0.
- **Decimal point:** `dp_mask`=8'h01, digit 0 value 0 → `seg`=40. Other digits keep bit7=1.
- **Reset mid-slot:** assert `rst` at `idx`=5, `cnt`=4.
  - Next cycle: `an`=FF, `seg`=FF.
  - After release: new snapshot taken, and the first lit digit is digit 0 after the 2-cycle gap.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and hex-to-segment lookup for 7-segment
//                display blocks (active-low cathodes, segment order g..a).
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // All cathodes off (dp included) and all anodes off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} pattern for each hex digit 0..F.
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        return HEX_SEG_TABLE[nib];
    endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver_if
//  Description : Board-IO side (data, dp mask, LZ enable) and pin side
//                (anodes, cathodes, frame tick) of the 7-segment scanner.
//  Revision    : 1.0  initial release
// ============================================================================
interface seg7_scan_driver_if;
    logic [31:0] seg7_data;
    logic [7:0]  dp_mask;
    logic        blank_lz;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    // Peripheral / environment side.
    modport master (
        output seg7_data, dp_mask, blank_lz,
        input  an, seg, frame_tick
    );

    // Scanner side.
    modport slave (
        input  seg7_data, dp_mask, blank_lz,
        output an, seg, frame_tick
    );
endinterface : seg7_scan_driver_if
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decode
//  Description : Combinational hex nibble to active-low 7-segment pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    // Table lookup shared with every display block through the package.
    always_comb begin
        o_seg = hex2seg(i_nib);
    end

endmodule : seg7_hex_decode
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed scanner for an 8-digit 7-segment display.
//                Snapshots the input word once per frame (tear-free), blanks
//                the first GAP cycles of each digit slot (anti-ghosting) and
//                optionally blanks leading-zero digits.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIV = 50000,   // clka cycles per digit slot
    parameter int unsigned GAP = 500      // blank cycles at slot start, 1 <= GAP < DIV
)(
    input  logic                clka,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus
);

    localparam int unsigned      CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_GAP      = CNT_W'(GAP);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      snap_data_q, snap_data_d;
    logic [7:0]       snap_dp_q, snap_dp_d;
    logic             snap_lz_q, snap_lz_d;
    logic [7:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_tick_q, frame_tick_d;

    logic             w_load;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg_dec;
    logic [8:1]       w_upper_zero;   // [j]: nibbles j..7 of the snapshot are all zero
    logic [7:0]       w_lz_digit;     // [j]: digit j is leading-zero blanked

    assign w_load = (cnt_q == '0) && (idx_q == 3'd0);
    assign w_nib  = snap_data_q[4*idx_q +: 4];

    // Zero-chain from the most significant nibble downward.
    assign w_upper_zero[8] = 1'b1;
    assign w_lz_digit[0]   = 1'b0;   // digit 0 always shows, even when zero
    for (genvar j = 1; j < 8; j++) begin : g_lz
        assign w_upper_zero[j] = (snap_data_q[4*j +: 4] == 4'h0) && w_upper_zero[j+1];
        assign w_lz_digit[j]   = snap_lz_q && w_upper_zero[j];
    end

    seg7_hex_decode u_hex_decode (
        .i_nib (w_nib),
        .o_seg (w_seg_dec)
    );

    // Next-state: slot counter, digit index, frame snapshot and pin drive.
    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        snap_data_d  = snap_data_q;
        snap_dp_d    = snap_dp_q;
        snap_lz_d    = snap_lz_q;
        frame_tick_d = w_load;
        an_d         = AN_OFF;
        seg_d        = SEG_BLANK;

        if (cnt_q == C_CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end

        // Snapshot is taken while the slot is still in its blank gap.
        if (w_load) begin
            snap_data_d = bus.seg7_data;
            snap_dp_d   = bus.dp_mask;
            snap_lz_d   = bus.blank_lz;
        end

        if ((cnt_q >= C_GAP) && !w_lz_digit[idx_q]) begin
            an_d  = ~(8'b1 << idx_q);
            seg_d = {~snap_dp_q[idx_q], w_seg_dec};
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clka) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            snap_data_q  <= 32'h0;
            snap_dp_q    <= 8'h0;
            snap_lz_q    <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            snap_data_q  <= snap_data_d;
            snap_dp_q    <= snap_dp_d;
            snap_lz_q    <= snap_lz_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.frame_tick = frame_tick_q;

endmodule : seg7_scan_driver
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Self-checking bench for seg7_scan_driver (DIV=8, GAP=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int DIV   = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 8 * DIV;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic        lz;
        int          digit;
        logic [7:0]  exp_an;
        logic [7:0]  exp_seg;
    } vec_t;

    logic clka = 1'b0;
    logic rst  = 1'b1;
    always #5 clka = ~clka;

    seg7_scan_driver_if bus();

    seg7_scan_driver #(.DIV(DIV), .GAP(GAP)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    // Reference display glyphs, dp off.
    logic [7:0] ref_hex [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_pos    = 0;     // frame position of the next non-reset edge
    int          last_p   = -1;    // frame position of the last edge (-1 = reset)
    logic [31:0] m_data   = '0;
    logic [7:0]  m_dp     = '0;
    logic        m_lz     = 1'b0;
    logic [7:0]  exp_an, exp_seg;
    logic        exp_ft;
    int          since_ft = 0;
    bit          ft_seen  = 1'b0;
    vec_t        vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] m_nib(input int d);
        return 4'((m_data >> (4 * d)) & 32'hF);
    endfunction

    function automatic bit m_lz_blank(input int d);
        if (!m_lz || d == 0) return 1'b0;
        for (int j = d; j < 8; j++)
            if (m_nib(j) != 4'h0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: advance the reference model, then compare all outputs.
    task automatic step();
        int p, d, c;
        @(posedge clka);
        if (rst) begin
            exp_an = 8'hFF; exp_seg = 8'hFF; exp_ft = 1'b0;
            m_data = '0; m_dp = '0; m_lz = 1'b0;
            m_pos  = 0;  last_p = -1;
        end else begin
            p = m_pos; d = p / DIV; c = p % DIV;
            exp_ft = (p == 0);
            if (c < GAP || m_lz_blank(d)) begin
                exp_an = 8'hFF; exp_seg = 8'hFF;
            end else begin
                exp_an  = ~(8'h01 << d);
                exp_seg = ref_hex[m_nib(d)] & (m_dp[d] ? 8'h7F : 8'hFF);
            end
            if (p == 0) begin
                m_data = bus.seg7_data; m_dp = bus.dp_mask; m_lz = bus.blank_lz;
            end
            last_p = p;
            m_pos  = (p + 1) % FRAME;
        end
        #1;
        chk("an", bus.an, exp_an);
        chk("seg", bus.seg, exp_seg);
        chk("frame_tick", bus.frame_tick, exp_ft);
        chk("an_onehot", ($countones(~bus.an) <= 1), 1);
        since_ft++;
        if (rst) begin
            ft_seen = 1'b0;
        end else if (bus.frame_tick) begin
            if (ft_seen) chk("ft_period", since_ft, FRAME);
            ft_seen  = 1'b1;
            since_ft = 0;
        end
    endtask

    // Step until the last edge handled frame position target.
    task automatic run_to(input int target);
        int n = 0;
        do begin
            step();
            n++;
        end while (last_p != target && n < 3 * FRAME);
        if (last_p != target) begin
            n_checks++; n_fail++;
            $display("FAIL run_to_timeout: got pos %0d expected %0d", last_p, target);
        end
    endtask

    task automatic set_in(input logic [31:0] d, input logic [7:0] dp, input logic lz);
        bus.seg7_data = d; bus.dp_mask = dp; bus.blank_lz = lz;
    endtask

    initial begin
        vecs[0]  = '{32'h76543210, 8'h00, 1'b0, 0, 8'hFE, 8'hC0};
        vecs[1]  = '{32'h76543210, 8'h00, 1'b0, 1, 8'hFD, 8'hF9};
        vecs[2]  = '{32'h76543210, 8'h00, 1'b0, 7, 8'h7F, 8'hF8};
        vecs[3]  = '{32'h00000A00, 8'h00, 1'b1, 2, 8'hFB, 8'h88};
        vecs[4]  = '{32'h00000A00, 8'h00, 1'b1, 1, 8'hFD, 8'hC0};
        vecs[5]  = '{32'h00000A00, 8'h00, 1'b1, 3, 8'hFF, 8'hFF};
        vecs[6]  = '{32'h00000000, 8'h00, 1'b1, 0, 8'hFE, 8'hC0};
        vecs[7]  = '{32'h00000000, 8'h00, 1'b1, 5, 8'hFF, 8'hFF};
        vecs[8]  = '{32'h00000000, 8'h01, 1'b0, 0, 8'hFE, 8'h40};
        vecs[9]  = '{32'h00000000, 8'h01, 1'b0, 1, 8'hFD, 8'hC0};
        vecs[10] = '{32'hFFFFFFFF, 8'h00, 1'b0, 4, 8'hEF, 8'h8E};
        vecs[11] = '{32'h12345678, 8'h80, 1'b0, 7, 8'h7F, 8'h79};
        vecs[12] = '{32'h0000B000, 8'h00, 1'b1, 3, 8'hF7, 8'h83};

        set_in(32'h76543210, 8'h00, 1'b0);

        // Reset held three cycles, then release.
        rst = 1'b1;
        repeat (3) step();
        chk("reset_an", bus.an, 8'hFF);
        chk("reset_seg", bus.seg, 8'hFF);
        chk("reset_ft", bus.frame_tick, 1'b0);
        rst = 1'b0;
        step();
        chk("ft_after_release", bus.frame_tick, 1'b1);
        step();
        chk("ft_one_cycle", bus.frame_tick, 1'b0);

        // Table-driven digit checks.
        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].data, vecs[i].dp, vecs[i].lz);
            run_to(0);
            run_to(vecs[i].digit * DIV + GAP);
            chk($sformatf("vec%0d_an", i), bus.an, vecs[i].exp_an);
            chk($sformatf("vec%0d_seg", i), bus.seg, vecs[i].exp_seg);
        end

        // Tear-free: change data mid-frame at idx 3.
        set_in(32'h76543210, 8'h00, 1'b0);
        run_to(0);
        run_to(3 * DIV);
        set_in(32'hFFFFFFFF, 8'h00, 1'b0);
        run_to(3 * DIV + GAP);
        chk("tear_d3", bus.seg, 8'hB0);
        run_to(5 * DIV + GAP);
        chk("tear_d5", bus.seg, 8'h92);
        run_to(7 * DIV + GAP);
        chk("tear_d7", bus.seg, 8'hF8);
        run_to(0);
        run_to(GAP);
        chk("tear_next_d0", bus.seg, 8'h8E);
        run_to(6 * DIV + GAP);
        chk("tear_next_d6", bus.seg, 8'h8E);

        // Reset mid-slot at idx 5, cnt 4.
        run_to(5 * DIV + 3);
        rst = 1'b1;
        set_in(32'h12345678, 8'h00, 1'b0);
        step();
        chk("midrst_an", bus.an, 8'hFF);
        chk("midrst_seg", bus.seg, 8'hFF);
        rst = 1'b0;
        step();
        chk("midrst_ft", bus.frame_tick, 1'b1);
        step();
        chk("midrst_gap_an", bus.an, 8'hFF);
        step();
        chk("midrst_first_an", bus.an, 8'hFE);
        chk("midrst_first_seg", bus.seg, 8'h80);

        // Randomized inputs changing at arbitrary times, checked every cycle.
        for (int f = 0; f < 30 * FRAME; f++) begin
            if ($urandom_range(0, 15) == 0) begin
                bus.seg7_data = $urandom >> $urandom_range(0, 32);
                bus.dp_mask   = 8'($urandom);
                bus.blank_lz  = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg7_scan_driver
`default_nettype wire
